// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings and FSM state type for the hazard controller
package hazard_ctrl_pkg;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_WAIT = 1'b1;
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: EX operand forwarding selects, MEM result preferred over WB
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          mem_reg_write,
  input  logic          wb_reg_write,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);
  logic mem_ok, wb_ok;
  // x0 is never forwarded since it always reads as zero
  always_comb begin
    mem_ok = mem_reg_write && mem_rd != '0;
    wb_ok  = wb_reg_write && wb_rd != '0;
    fwd_a  = (mem_ok && mem_rd == ex_rs1) ? FWD_MEM : (wb_ok && wb_rd == ex_rs1) ? FWD_WB : FWD_RF;
    fwd_b  = (mem_ok && mem_rd == ex_rs2) ? FWD_MEM : (wb_ok && wb_rd == ex_rs2) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with dmem wait watchdog and perf counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int         RW       = 5,
  parameter int         CNT_W    = 32,
  parameter int         TIMEOUT  = 16,
  parameter logic [1:0] LOAD_SRC = RS_LOAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RW-1:0]    ex_rs1,
  input  logic [RW-1:0]    ex_rs2,
  input  logic [RW-1:0]    ex_rd,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic [RW-1:0]    mem_rd,
  input  logic [RW-1:0]    wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             dmem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          load_use, freeze, redirect, bubble;
  fwd_unit #(.RW(RW)) u_fwd (
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  // busy freezes everything in either state; once it drops the RUN priorities apply to the held EX/ID contents
  always_comb begin
    load_use    = ex_result_src == LOAD_SRC && ex_rd != '0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    freeze      = rst && dmem_busy;
    redirect    = rst && !dmem_busy && ex_pc_src;
    bubble      = rst && !dmem_busy && !ex_pc_src && load_use;
    stall_pc    = freeze || bubble;
    stall_ifid  = freeze || bubble;
    stall_idex  = freeze;
    stall_exmem = freeze;
    flush_ifid  = redirect;
    flush_idex  = redirect || bubble;
  end
  // wait sequencing and sticky watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (dmem_busy) begin
      state <= ST_WAIT;
      if (state == ST_RUN) wait_cnt <= TW'(1);
      else if (wait_cnt != TW'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_WAIT && wait_cnt >= TW'(TIMEOUT - 1)) mem_timeout <= 1'b1;
    end else begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end
  end
  // saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((flush_ifid || flush_idex) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a rule-level model
module tb_hazard_ctrl;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_pc_src, mem_reg_write, wb_reg_write, dmem_busy;
  logic [1:0] ex_result_src, fwd_a, fwd_b;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0] ctl;
  int checks = 0, failures = 0;
  logic [31:0] m_stall, m_flush;
  int m_run;
  logic m_to;

  hazard_ctrl #(.RW(5), .CNT_W(32), .TIMEOUT(TIMEOUT), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .dmem_busy(dmem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex};

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [5:0] m_ctl();
    logic lu;
    lu = ex_result_src == 2'b01 && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst) return 6'b000000;
    if (dmem_busy) return 6'b111100;
    if (ex_pc_src) return 6'b000011;
    if (lu) return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_pc_src, mem_reg_write, wb_reg_write, dmem_busy} = '0;
    ex_result_src = 2'b00;
  endtask

  task automatic cycle();
    logic [5:0] e;
    e = m_ctl();
    @(posedge clk);
    if (rst) begin
      if (e[5] && m_stall != '1) m_stall++;
      if ((e[1] || e[0]) && m_flush != '1) m_flush++;
      m_run = dmem_busy ? m_run + 1 : 0;
      if (m_run >= TIMEOUT) m_to = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    dmem_busy = 1'b1; ex_pc_src = 1'b1;
    #1;
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
    do_reset();
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    checks++; if (ctl !== 6'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b %b %b exp=000000 00 00", ctl, fwd_a, fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_result_src = 2'b01; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== 6'b110001) begin failures++; $display("FAIL load_use_ctl got=%b exp=110001", ctl); end
    cycle();
    ex_result_src = 2'b00;
    #1;
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL load_use_release got=%b exp=000000", ctl); end
    checks++; if (stall_cnt !== 1 || flush_cnt !== 1) begin failures++; $display("FAIL load_use_cnt got=%0d/%0d exp=1/1", stall_cnt, flush_cnt); end
    ex_result_src = 2'b01; ex_rd = 0; id_rs1 = 0;
    #1;
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL load_use_x0 got=%b exp=000000", ctl); end
    ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1'b0;
    #1;
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL load_use_unused got=%b exp=000000", ctl); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_result_src = 2'b01; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1'b1; ex_pc_src = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000011) begin failures++; $display("FAIL redirect_ctl got=%b exp=000011", ctl); end
    cycle();
    checks++; if (flush_cnt !== 1 || stall_cnt !== 0) begin failures++; $display("FAIL redirect_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    mem_rd = 7; wb_rd = 7; ex_rs2 = 7; ex_rs1 = 3; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    #1;
    checks++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin failures++; $display("FAIL fwd_priority got=%b/%b exp=10/00", fwd_b, fwd_a); end
    mem_reg_write = 1'b0;
    #1;
    checks++; if (fwd_b !== 2'b01) begin failures++; $display("FAIL fwd_wb got=%b exp=01", fwd_b); end
    mem_reg_write = 1'b1; mem_rd = 0; wb_rd = 0; ex_rs2 = 0;
    #1;
    checks++; if (fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_x0 got=%b exp=00", fwd_b); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ex_pc_src = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== 6'b111100) begin failures++; $display("FAIL mem_wait_ctl cyc=%0d got=%b exp=111100", i, ctl); end
      cycle();
    end
    dmem_busy = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000011) begin failures++; $display("FAIL mem_wait_exit got=%b exp=000011", ctl); end
    cycle();
    checks++; if (stall_cnt !== 3 || flush_cnt !== 1) begin failures++; $display("FAIL mem_wait_cnt got=%0d/%0d exp=3/1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_busy = 1'b1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle();
      checks++;
      if (mem_timeout !== (i >= TIMEOUT)) begin failures++; $display("FAIL timeout edge=%0d got=%b exp=%b", i, mem_timeout, i >= TIMEOUT); end
    end
    dmem_busy = 1'b0;
    repeat (3) cycle();
    checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
    checks++; if (stall_cnt !== TIMEOUT) begin failures++; $display("FAIL timeout_cnt got=%0d exp=%0d", stall_cnt, TIMEOUT); end
    do_reset();
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_pc_src = 1'b1; dmem_busy = 1'b1;
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1;
    checks++; if (ctl !== 6'b0 || stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b %0d %0d %b exp=000000 0 0 0", ctl, stall_cnt, flush_cnt, mem_timeout);
    end
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
    dmem_busy = 1'b0; ex_pc_src = 1'b0;
    #2 rst = 1'b1;
    cycle();
    checks++; if (ctl !== 6'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL async_release got=%b %0d %0d exp=000000 0 0", ctl, stall_cnt, flush_cnt); end
    dmem_busy = 1'b1;
    repeat (TIMEOUT - 1) cycle();
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL async_wait_restart got=%b exp=0", mem_timeout); end
    dmem_busy = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [5:0] ec;
    logic [1:0] ea, eb;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      id_rs1 = 5'($urandom_range(0, 4)); id_rs2 = 5'($urandom_range(0, 4));
      ex_rs1 = 5'($urandom_range(0, 4)); ex_rs2 = 5'($urandom_range(0, 4));
      ex_rd = 5'($urandom_range(0, 4)); mem_rd = 5'($urandom_range(0, 4)); wb_rd = 5'($urandom_range(0, 4));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      ex_result_src = 2'($urandom);
      ex_pc_src = $urandom_range(0, 4) == 0;
      dmem_busy = (n % 100 >= 70 && n % 100 < 90) ? 1'b1 : $urandom_range(0, 3) == 0;
      #1;
      ec = m_ctl(); ea = m_fwd(ex_rs1); eb = m_fwd(ex_rs2);
      checks++; if (ctl !== ec) begin failures++; $display("FAIL rand_ctl n=%0d got=%b exp=%b", n, ctl, ec); end
      checks++; if (fwd_a !== ea || fwd_b !== eb) begin failures++; $display("FAIL rand_fwd n=%0d got=%b/%b exp=%b/%b", n, fwd_a, fwd_b, ea, eb); end
      cycle();
      checks++; if (stall_cnt !== m_stall || flush_cnt !== m_flush || mem_timeout !== m_to) begin
        failures++; $display("FAIL rand_regs n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_to);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Generates stall/flush for the PC, IF/ID and ID/EX pipeline registers, and forwarding selects for the EX operand muxes.
- Sequences a freeze of all stages while data memory is busy, with a timeout watchdog.
- Keeps saturating stall and flush performance counters.

Parameters:
- RW, 5, register index width
- CNT_W, 32, performance counter width
- TIMEOUT, 16, max consecutive busy cycles before mem_timeout sets (>=2)
- LOAD_SRC, 2'b01, Result_Src encoding that marks a load in EX

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  RW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  RW  source registers of the instruction in EX
- ex_rd  in  RW  EX destination
- ex_result_src  in  2  EX Result_Src
- ex_pc_src  in  1  taken branch / jal / jalr resolved in EX
- mem_rd, wb_rd  in  RW  MEM/WB destinations
- mem_reg_write, wb_reg_write  in  1  MEM/WB write enables
- dmem_busy  in  1  data memory not ready this cycle
- stall_pc, stall_ifid, stall_idex, stall_exmem  out  1  hold register
- flush_ifid, flush_idex  out  1  clear register to bubble
- fwd_a, fwd_b  out  2  00 regfile, 10 from MEM, 01 from WB
- mem_timeout  out  1  sticky watchdog error
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst=0, async):
  - state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - All stall/flush outputs are forced 0 while rst=0.
- Stall/flush/forward outputs are combinational from state and inputs (same-cycle effect); all other outputs are registered.
- Forwarding, per operand, evaluated every cycle including WAIT:
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a=00. MEM has priority over WB. fwd_b is identical using ex_rs2.
- load_use = ex_result_src==LOAD_SRC && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- FSM states RUN, WAIT.
- RUN, priority high to low:
  1. dmem_busy: all four stall_* = 1, no flush, next=WAIT, wait counter=1.
  2. ex_pc_src: flush_ifid=1, flush_idex=1, no stall. Overrides load_use, since ID holds a wrong-path instruction.
  3. load_use: stall_pc=1, stall_ifid=1, flush_idex=1 (one bubble, exactly one cycle).
  4. Otherwise all 0.
- WAIT:
  - All stall_* = 1, flush_* = 0; ex_pc_src and load_use are ignored.
  - They are re-evaluated in RUN, because the frozen EX/ID contents persist.
  - dmem_busy=0: outputs for this cycle are computed as in RUN, next=RUN, wait counter=0.
  - dmem_busy=1: wait counter increments, saturating at TIMEOUT. When the counter reaches TIMEOUT, mem_timeout sets on that edge and remains set until reset; the FSM stays in WAIT.
- Counters:
  - stall_cnt +1 on each cycle with stall_pc=1.
  - flush_cnt +1 on each cycle with flush_ifid|flush_idex.
  - Both saturate at all-ones, never wrap.
- Reset mid-WAIT returns immediately to RUN with outputs 0.

Decomposition:
- Shared package holds:
  - the Result_Src encodings (LOAD_SRC);
  - the fwd encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - the FSM state typedef.
- One natural sub-module: fwd_unit (combinational, instantiated once, both operands).

Test Plan:
- Load-use: ex_result_src=01, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; stall_cnt=1.
- Redirect plus load-use in the same cycle: ex_pc_src=1 with load_use true -> flush_ifid=flush_idex=1, stall_pc=0, flush_cnt=1, stall_cnt=0.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both write enables=1 -> fwd_b=10. With rd=0 for both -> fwd_b=00.
- Memory wait: dmem_busy high for 3 cycles with ex_pc_src=1 -> 3 cycles all stalls=1 and flush=0; in the cycle busy drops, flush_ifid=flush_idex=1; stall_cnt=3.
- Timeout: dmem_busy held 16 cycles (TIMEOUT=16) -> mem_timeout=1 after the 16th edge and remains 1 after busy drops; it clears only on reset.
- Async reset asserted mid-WAIT, between clock edges -> all outputs 0 immediately; after release, state=RUN and counters=0.
